// File: rtl/hdb3_pkg.sv
// Shared types and constants for the HDB3 transmit scheduler.
package hdb3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam int unsigned DIV_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned BIT_W = 3;

    localparam logic [7:0] SYNC_WORD = 8'hA5;
    localparam logic [7:0] FILL_BYTE = 8'h00;
    localparam logic [6:0] PRBS_SEED = 7'h7F;

endpackage

// File: rtl/hdb3_prbs7.sv
// PRBS7 (x^7 + x^6 + 1) idle-pattern generator; advances one step per adv.
module hdb3_prbs7
    import hdb3_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic adv,
    output logic bit_out
);

    logic [6:0] lfsr;

    assign bit_out = lfsr[6] ^ lfsr[5];

    // Shift left inserting the output bit on each advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= PRBS_SEED;
        end else if (adv) begin
            lfsr <= {lfsr[5:0], bit_out};
        end
    end

endmodule

// File: rtl/hdb3_tx_sched.sv
// Frame scheduler feeding a serial HDB3 encoder: idle bits, SYNC_WORD, then
// FRAME_BYTES payload bytes MSB first, one bit per divider tick.
// Optional macro HDB3_TX_PRBS_EN: idle bits come from a PRBS7 generator
// instead of constant zero.
module hdb3_tx_sched
    import hdb3_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned FRAME_BYTES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       enc_din,
    output logic       enc_ce,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [7:0]         shifter;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         hold;

    logic               tick_c;
    logic               start_c;
    logic               load_c;
    logic [7:0]         load_byte_c;
    logic               idle_bit_c;

    assign tick_c      = (div == DIV_W'(CLK_DIV - 1));
    assign start_c     = tick_c && (state == ST_IDLE) && tx_en && !s_ready;
    assign load_c      = tick_c && (state == ST_DATA) && (bit_cnt == '0);
    assign load_byte_c = s_ready ? FILL_BYTE : hold;

`ifdef HDB3_TX_PRBS_EN
    logic prbs_adv_c;

    assign prbs_adv_c = tick_c && (state == ST_IDLE) && !start_c;

    hdb3_prbs7 u_prbs (
        .clk     (clk),
        .rst     (rst),
        .adv     (prbs_adv_c),
        .bit_out (idle_bit_c)
    );
`else
    assign idle_bit_c = 1'b0;
`endif

    // Free-running bit-rate divider.
    always_ff @(posedge clk) begin
        if (rst || tick_c) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // One-byte holding register; s_ready doubles as its empty flag and an
    // accept wins over a simultaneous load so the register stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready <= 1'b1;
            hold    <= '0;
        end else if (s_valid && s_ready) begin
            hold    <= s_data;
            s_ready <= 1'b0;
        end else if (load_c) begin
            s_ready <= 1'b1;
        end
    end

    // Frame FSM with registered encoder-side outputs, updated once per tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            enc_din    <= 1'b0;
            enc_ce     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            enc_ce     <= tick_c;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            if (tick_c) begin
                case (state)
                    ST_IDLE: begin
                        if (start_c) begin
                            enc_din <= SYNC_WORD[7];
                            shifter <= {SYNC_WORD[6:0], 1'b0};
                            bit_cnt <= BIT_W'(1);
                            busy    <= 1'b1;
                            state   <= ST_SYNC;
                        end else begin
                            enc_din <= idle_bit_c;
                        end
                    end
                    ST_SYNC: begin
                        enc_din <= shifter[7];
                        shifter <= {shifter[6:0], 1'b0};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(7)) begin
                            byte_cnt <= '0;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_cnt == '0) begin
                            enc_din  <= load_byte_c[7];
                            shifter  <= {load_byte_c[6:0], 1'b0};
                            underrun <= s_ready;
                        end else begin
                            enc_din <= shifter[7];
                            shifter <= {shifter[6:0], 1'b0};
                        end
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_W'(7)) begin
                            if (byte_cnt == CNT_W'(FRAME_BYTES - 1)) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                byte_cnt   <= '0;
                                state      <= ST_IDLE;
                            end else begin
                                byte_cnt <= byte_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdb3_tx_sched.sv
// Scoreboard bench for hdb3_tx_sched with CLK_DIV=4, FRAME_BYTES=2.
module tb_hdb3_tx_sched;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned FRAME_BYTES = 2;

    logic       clk;
    logic       rst;
    logic       tx_en;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       enc_din;
    logic       enc_ce;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int n_checks = 0;
    int n_fails  = 0;

    logic [2:0] exp_q[$];   // {din, frame_done, underrun} per tick
    logic [7:0] tx_q[$];

    hdb3_tx_sched #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_BYTES (FRAME_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .enc_din    (enc_din),
        .enc_ce     (enc_ce),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * CLK_DIV && !ok; i++) begin
            @(posedge clk); #1;
            if (enc_ce) ok = 1'b1;
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (enc_ce && busy) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; tx_en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        tx_q.delete();
    endtask

    task automatic sb_push(input logic [7:0] b, input bit last, input bit ur);
        for (int i = 7; i >= 0; i--)
            exp_q.push_back({b[i], last && (i == 0), ur && (i == 7)});
    endtask

    task automatic drive_bytes();
        bit acc;
        while (tx_q.size() > 0) begin
            s_data  = tx_q[0];
            s_valid = 1'b1;
            acc     = 1'b0;
            for (int i = 0; i < 400 && !acc; i++) begin
                acc = s_ready;
                @(posedge clk); #1;
            end
            n_checks++;
            if (!acc) begin
                n_fails++;
                $display("FAIL push_timeout byte=%h not accepted within 400 cycles", tx_q[0]);
            end
            void'(tx_q.pop_front());
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1; tx_en = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        @(posedge clk); #1;
        got = {enc_din, enc_ce, busy, frame_done, underrun, s_ready};
        n_checks++;
        if (got !== 6'b000001) begin
            n_fails++;
            $display("FAIL reset_hold got=%b exp=000001", got);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        got = {enc_din, enc_ce, busy, frame_done, underrun, s_ready};
        n_checks++;
        if (got !== 6'b000001) begin
            n_fails++;
            $display("FAIL reset_release got=%b exp=000001", got);
        end
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            got = {enc_din, enc_ce, busy, frame_done, underrun, s_ready};
            n_checks++;
            if (got !== {1'b0, (k % 4) == 0, 4'b0001}) begin
                n_fails++;
                $display("FAIL idle_divider cycle=%0d got=%b exp=%b", k, got,
                         {1'b0, (k % 4) == 0, 4'b0001});
            end
        end
    endtask

    task automatic test_idle_bits();
        logic [7:0] pat;
        bit ok;
`ifdef HDB3_TX_PRBS_EN
        pat = 8'b0000_0010;
`else
        pat = 8'b0000_0000;
`endif
        do_reset();
        for (int k = 0; k < 8; k++) begin
            wait_tick(ok);
            n_checks++;
            if (!ok || enc_din !== pat[7-k] || busy !== 1'b0) begin
                n_fails++;
                $display("FAIL idle_bit idx=%0d tick=%0d din=%b busy=%b exp_din=%b", k, ok, enc_din, busy, pat[7-k]);
            end
        end
    endtask

    task automatic test_frame();
        bit ok;
        logic [2:0] e;
        do_reset();
        tx_en = 1'b1;
        tx_q = '{8'h3C, 8'h81};
        sb_push(8'hA5, 0, 0); sb_push(8'h3C, 0, 0); sb_push(8'h81, 1, 0);
        fork
            drive_bytes();
            begin
                wait_start(ok);
                for (int k = 0; k < 24 && ok; k++) begin
                    if (k > 0) wait_tick(ok);
                    e = exp_q.pop_front();
                    n_checks++;
                    if (!ok || {enc_din, frame_done, underrun} !== e) begin
                        n_fails++;
                        $display("FAIL frame_bit idx=%0d tick=%0d got=%b exp=%b", k, ok,
                                 {enc_din, frame_done, underrun}, e);
                    end
                end
            end
        join
        for (int k = 0; k < 8; k++) begin
            wait_tick(ok);
            n_checks++;
`ifdef HDB3_TX_PRBS_EN
            if (!ok || {busy, frame_done} !== 2'b00) begin
`else
            if (!ok || {enc_din, busy, frame_done} !== 3'b000) begin
`endif
                n_fails++;
                $display("FAIL post_frame_idle idx=%0d tick=%0d din=%b busy=%b fd=%b", k, ok, enc_din, busy, frame_done);
            end
        end
    endtask

    task automatic test_underrun();
        bit ok;
        logic [2:0] e;
        do_reset();
        tx_en = 1'b1;
        tx_q = '{8'h3C};
        sb_push(8'hA5, 0, 0); sb_push(8'h3C, 0, 0); sb_push(8'h00, 1, 1);
        fork
            drive_bytes();
            begin
                wait_start(ok);
                for (int k = 0; k < 24 && ok; k++) begin
                    if (k > 0) wait_tick(ok);
                    e = exp_q.pop_front();
                    n_checks++;
                    if (!ok || {enc_din, frame_done, underrun} !== e) begin
                        n_fails++;
                        $display("FAIL underrun_bit idx=%0d tick=%0d got=%b exp=%b", k, ok,
                                 {enc_din, frame_done, underrun}, e);
                    end
                end
            end
        join
    endtask

    task automatic test_tx_drop();
        bit ok;
        logic [2:0] e;
        do_reset();
        tx_en = 1'b1;
        tx_q = '{8'h3C, 8'h81, 8'h5A};
        sb_push(8'hA5, 0, 0); sb_push(8'h3C, 0, 0); sb_push(8'h81, 1, 0);
        fork
            drive_bytes();
            begin
                wait_start(ok);
                tx_en = 1'b0;
                for (int k = 0; k < 24 && ok; k++) begin
                    if (k > 0) wait_tick(ok);
                    e = exp_q.pop_front();
                    n_checks++;
                    if (!ok || {enc_din, frame_done, underrun} !== e) begin
                        n_fails++;
                        $display("FAIL txdrop_bit idx=%0d tick=%0d got=%b exp=%b", k, ok,
                                 {enc_din, frame_done, underrun}, e);
                    end
                end
            end
        join
        for (int k = 0; k < 6; k++) begin
            wait_tick(ok);
            n_checks++;
            if (!ok || busy !== 1'b0 || s_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL txdrop_hold idx=%0d tick=%0d busy=%b s_ready=%b exp busy=0 s_ready=0", k, ok, busy, s_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [2:0] e;
        do_reset();
        tx_en = 1'b1;
        tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        sb_push(8'hA5, 0, 0); sb_push(8'h11, 0, 0); sb_push(8'h22, 1, 0);
        sb_push(8'hA5, 0, 0); sb_push(8'h33, 0, 0); sb_push(8'h44, 1, 0);
        fork
            drive_bytes();
            begin
                wait_start(ok);
                for (int k = 0; k < 48 && ok; k++) begin
                    if (k > 0) wait_tick(ok);
                    e = exp_q.pop_front();
                    n_checks++;
                    if (!ok || {enc_din, frame_done, underrun} !== e) begin
                        n_fails++;
                        $display("FAIL b2b_bit idx=%0d tick=%0d got=%b exp=%b", k, ok,
                                 {enc_din, frame_done, underrun}, e);
                    end
                end
            end
        join
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit saw;
        logic [5:0] got;
        do_reset();
        tx_en = 1'b1;
        tx_q = '{8'h3C, 8'h81};
        fork
            drive_bytes();
            begin
                wait_start(ok);
                for (int k = 1; k <= 13 && ok; k++) wait_tick(ok);
                n_checks++;
                if (!ok) begin
                    n_fails++;
                    $display("FAIL midreset_reach tick timeout before DATA bit 5");
                end
            end
        join
        rst = 1'b1;
        @(posedge clk); #1;
        got = {enc_din, enc_ce, busy, frame_done, underrun, s_ready};
        n_checks++;
        if (got !== 6'b000001) begin
            n_fails++;
            $display("FAIL midreset_outputs got=%b exp=000001", got);
        end
        rst = 1'b0;
        tx_en = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (frame_done || busy || !s_ready) saw = 1'b1;
        end
        n_checks++;
        if (saw) begin
            n_fails++;
            $display("FAIL midreset_after frame_done/busy/not-empty seen=1 exp=0");
        end
    endtask

    initial begin
        test_reset();
        test_idle_bits();
        test_frame();
        test_underrun();
        test_tx_drop();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hdb3_tx_sched.md
HDB3_TX_SCHED -- requirements
Module: hdb3_tx_sched

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per line bit (legal range 1..255).
REQ-002 SHALL have parameter FRAME_BYTES, default 8, payload bytes per frame (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port tx_en, input, 1, permits frame start.
REQ-006 SHALL have port s_data, input, 8, payload byte.
REQ-007 SHALL have port s_valid, input, 1, s_data valid.
REQ-008 SHALL have port s_ready, output, 1, byte accepted when s_valid&&s_ready.
REQ-009 SHALL have port enc_din, output, 1, serial bit to the HDB3 encoder.
REQ-010 SHALL have port enc_ce, output, 1, encoder clock-enable, one-cycle pulse per bit.
REQ-011 SHALL have port busy, output, 1, high in SYNC or DATA.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse on the last bit of a frame.
REQ-013 SHALL have port underrun, output, 1, one-cycle pulse when a fill byte is substituted.

Function
REQ-014 SHALL pulse enc_ce once every CLK_DIV cycles from a free-running divider (0..CLK_DIV-1, wraps); CLK_DIV=1 gives enc_ce constantly high.
REQ-015 SHALL register enc_din and enc_ce; enc_din changes only in the tick cycle and holds its value between ticks.
REQ-016 SHALL transmit every byte MSB first, one bit per tick.
REQ-017 SHALL have a one-byte holding register; s_ready = holding register empty; an accept and a load in the same cycle leave the register full.
REQ-018 SHALL use FSM IDLE -> SYNC -> DATA -> IDLE.
REQ-019 In IDLE, SHALL send idle bits (0) each tick; at a tick with tx_en=1 and the holding register full, SHALL move to SYNC with that tick carrying SYNC_WORD bit 7.
REQ-020 In SYNC, SHALL send SYNC_WORD (8'hA5), then DATA.
REQ-021 In DATA, SHALL send FRAME_BYTES bytes; at each byte boundary, SHALL load the shifter from the holding register (emptying it).
REQ-022 If the holding register is empty at a DATA byte boundary, SHALL send FILL_BYTE (8'h00) and pulse underrun in that tick cycle; the byte count still advances.
REQ-023 SHALL pulse frame_done in the tick cycle of the last bit of byte FRAME_BYTES-1, then return to IDLE.
REQ-024 tx_en low in SYNC or DATA SHALL NOT abort the frame; it only blocks the next start.
REQ-025 Back-to-back frames: if tx_en=1 and the holding register is full at the tick after frame_done, SHALL start SYNC with zero idle bits between frames.

Reset
REQ-026 rst SHALL force state IDLE, divider 0, shifter and bit/byte counters 0, holding register empty.
REQ-027 During rst and in the first cycle after it, outputs SHALL be enc_din=0, enc_ce=0, busy=0, frame_done=0, underrun=0, s_ready=1.
REQ-028 rst asserted mid-frame SHALL discard the frame with no frame_done.

Configuration
REQ-029 With macro HDB3_TX_PRBS_EN defined, idle bits SHALL come from PRBS7 (x^7+x^6+1, seed 7'h7F, out=s[6]^s[5], shift left inserting out, advancing only on IDLE ticks); without it, idle bits SHALL be 0 and no PRBS logic SHALL exist.

Structure
REQ-030 Package hdb3_pkg SHALL hold the FSM state enum, SYNC_WORD, FILL_BYTE and PRBS seed.
REQ-031 The PRBS7 generator SHALL be sub-module hdb3_prbs7 (ports clk, rst, adv, bit_out), instantiated only under HDB3_TX_PRBS_EN.

Verification
REQ-032 Reset release, no input, CLK_DIV=4 -> enc_ce pulses every 4th cycle, enc_din=0, s_ready=1, busy=0.
REQ-033 FRAME_BYTES=2, tx_en=1, push 0x3C then 0x81 -> sampled bits 10100101 00111100 10000001, frame_done on 24th bit, then idle 0s.
REQ-034 FRAME_BYTES=2, push only 0x3C -> second byte 00000000, underrun exactly once at its first bit tick, frame_done still pulses.
REQ-035 Drop tx_en during SYNC -> full 24-bit frame still sent; no new frame while tx_en=0 even with a byte pending.
REQ-036 rst asserted at bit 5 of DATA -> next cycle all outputs at reset values; no frame_done; holding register empty.
REQ-037 HDB3_TX_PRBS_EN defined, idle -> first 8 idle bits 0,0,0,0,0,0,1,0.
